rx_fifo: RTL and testbench
==========================

Name: rx_fifo

Overview:
Receive-side frame buffer that sits directly downstream of the UART receiver top.
- Captures each completed frame (data plus parity/stop error flags) on a one-cycle completion strobe from the receiver.
- Holds frames in a circular buffer so the host can read them later through a first-word-fall-through pop interface.
- Drops stop-error (framing-error) frames and reports overrun and framing-error statistics.

Parameters:
DATA_WIDTH, 8, frame payload width; matches the UART data width.
DEPTH, 8, number of frame entries; power of two, ≥2.
CNT_WIDTH, 8, width of the saturating framing-error counter.

Ports:
RX_CLK  input  1  receiver clock; all state updates on rising edge
RX_RST  input  1  synchronous, active-high reset
WR_VALID  input  1  one-cycle pulse: frame complete, WR_* fields valid this cycle
WR_DATA  input  DATA_WIDTH  received payload
WR_PARITY_ERR  input  1  parity error flag for this frame
WR_STOP_ERR  input  1  stop-bit error flag for this frame
RD_EN  input  1  pop head entry at this clock edge
RD_DATA  output  DATA_WIDTH  head payload (fall-through)
RD_PARITY_ERR  output  1  parity flag of head entry
EMPTY  output  1  no entries stored
FULL  output  1  DEPTH entries stored
COUNT  output  clog2(DEPTH)+1  number of stored entries
OVERRUN  output  1  sticky: a valid frame was lost because the buffer was full
CLR_OVERRUN  input  1  clears OVERRUN
STOP_ERR_CNT  output  CNT_WIDTH  saturating count of dropped framing-error frames

Behaviour:
- Clock is RX_CLK. Reset RX_RST is synchronous and active-high.
- Reset (any time, including mid-operation):
  - write/read pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0, OVERRUN = 0, STOP_ERR_CNT = 0.
  - RD_DATA = 0 and RD_PARITY_ERR = 0 while EMPTY; entries in flight are discarded.
- Storage: DEPTH x (DATA_WIDTH+1) array, fields {parity_err, data}. Write pointer and read pointer are clog2(DEPTH) bits and wrap modulo DEPTH.
- Accepted write: WR_VALID=1 and WR_STOP_ERR=0 and (COUNT<DEPTH or a pop occurs in the same cycle).
  - Stores {WR_PARITY_ERR, WR_DATA} at wr_ptr; wr_ptr+1.
- Stop-error frame: WR_VALID=1 and WR_STOP_ERR=1.
  - Not stored. STOP_ERR_CNT+1, saturating at all-ones.
  - Never sets OVERRUN, even when the buffer is full.
- Overrun: WR_VALID=1, WR_STOP_ERR=0, FULL=1 and no pop this cycle.
  - Frame dropped, OVERRUN <= 1.
  - If CLR_OVERRUN is asserted in the same cycle, set wins.
- Pop: RD_EN=1 and EMPTY=0. rd_ptr+1. RD_EN while EMPTY is ignored (no pointer or count change).
- Fall-through: RD_DATA and RD_PARITY_ERR are combinational from the head entry, valid whenever EMPTY=0.
- Write latency: a frame written at edge N is visible on RD_DATA after edge N; EMPTY deasserts after that same edge.
- Simultaneous accepted write and pop:
  - COUNT unchanged.
  - When FULL, the write is accepted (the pop frees the slot) and there is no overrun.
  - When EMPTY, the pop is ignored and the write is accepted, so COUNT becomes 1.
- COUNT, EMPTY and FULL are registered/derived from COUNT: EMPTY = (COUNT==0), FULL = (COUNT==DEPTH).
- No state machine beyond pointer/count control; all outputs are glitch-free decodes of registers.

Test Plan:
1. Reset, then write 0xA5, 0x3C, 0xFF (parity_err 0,1,0) -> COUNT=3; pops return 0xA5/pe0, 0x3C/pe1, 0xFF/pe0; then EMPTY=1, RD_DATA=0.
2. Fill with 0x00..0x07 (DEPTH=8) -> FULL=1; write 0x55 -> dropped, OVERRUN=1, COUNT=8. Pulse CLR_OVERRUN -> OVERRUN=0. Drain -> 0x00..0x07 in order.
3. While FULL, write 0x99 with RD_EN the same cycle -> 0x00 popped, 0x99 stored, COUNT=8, OVERRUN=0. The final pop returns 0x99.
4. While EMPTY, write 0x42 with RD_EN the same cycle -> COUNT=1, RD_DATA=0x42.
5. Send 3 frames with WR_STOP_ERR=1 -> STOP_ERR_CNT=3, COUNT unchanged. Force the counter to 0xFF, send another -> stays 0xFF. Send one with FULL=1 -> OVERRUN stays 0.
6. Write 20 frames interleaved with pops (pointer wrap) -> output order and values match the reference queue model. Assert RX_RST with COUNT=5 -> next cycle COUNT=0, EMPTY=1, flags cleared.

Source files
------------

// File: rtl/rx_fifo.sv
// Receive frame buffer behind the UART receiver: FWFT circular store,
// framing-error frame drop, sticky overrun and saturating error count.
module rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    RX_CLK,
  input  logic                    RX_RST,
  input  logic                    WR_VALID,
  input  logic [DATA_WIDTH-1:0]   WR_DATA,
  input  logic                    WR_PARITY_ERR,
  input  logic                    WR_STOP_ERR,
  input  logic                    RD_EN,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  output logic                    RD_PARITY_ERR,
  output logic                    EMPTY,
  output logic                    FULL,
  output logic [$clog2(DEPTH):0]  COUNT,
  output logic                    OVERRUN,
  input  logic                    CLR_OVERRUN,
  output logic [CNT_WIDTH-1:0]    STOP_ERR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_overrun;
  logic [CNT_WIDTH-1:0]  r_stop_cnt;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_ovr;
  logic                  w_se;
  logic [DATA_WIDTH:0]   w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = RD_EN & ~w_empty;
  assign w_se    = WR_VALID & WR_STOP_ERR;
  // a pop in the same cycle frees the slot, so FULL alone does not drop
  assign w_wr    = WR_VALID & ~WR_STOP_ERR & (~w_full | w_pop);
  assign w_ovr   = WR_VALID & ~WR_STOP_ERR & w_full & ~w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge RX_CLK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {WR_PARITY_ERR, WR_DATA};
    end
  end

  always_ff @(posedge RX_CLK) begin
    if (RX_RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overrun  <= 1'b0;
      r_stop_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - 1'b1;
      end
      if (w_ovr) begin
        r_overrun <= 1'b1;
      end else if (CLR_OVERRUN) begin
        r_overrun <= 1'b0;
      end
      if (w_se && !(&r_stop_cnt)) begin
        r_stop_cnt <= r_stop_cnt + 1'b1;
      end
    end
  end

  assign RD_DATA       = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign RD_PARITY_ERR = w_empty ? 1'b0 : w_head[DATA_WIDTH];
  assign EMPTY         = w_empty;
  assign FULL          = w_full;
  assign COUNT         = r_count;
  assign OVERRUN       = r_overrun;
  assign STOP_ERR_CNT  = r_stop_cnt;

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: ordering, overrun, simultaneous
// read/write, framing-error drop/saturation, wrap and reset.
module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_pe;
  logic       wr_se;
  logic       rd_en;
  logic       clr;
  logic [7:0] rd_data;
  logic       rd_pe;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       ovr;
  logic [7:0] se_cnt;

  int checks = 0;
  int errors = 0;

  rx_fifo #(.DATA_WIDTH(8), .DEPTH(8), .CNT_WIDTH(8)) dut (
    .RX_CLK       (clk),
    .RX_RST       (rst),
    .WR_VALID     (wr_valid),
    .WR_DATA      (wr_data),
    .WR_PARITY_ERR(wr_pe),
    .WR_STOP_ERR  (wr_se),
    .RD_EN        (rd_en),
    .RD_DATA      (rd_data),
    .RD_PARITY_ERR(rd_pe),
    .EMPTY        (empty),
    .FULL         (full),
    .COUNT        (count),
    .OVERRUN      (ovr),
    .CLR_OVERRUN  (clr),
    .STOP_ERR_CNT (se_cnt)
  );

  always #5 clk = ~clk;

  // inputs change on negedge; one posedge; outputs sampled on next negedge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input logic pe,
                       input logic se, input logic rd);
    wr_valid = 1'b1; wr_data = d; wr_pe = pe; wr_se = se; rd_en = rd;
    cyc();
    wr_valid = 1'b0; wr_se = 1'b0; wr_pe = 1'b0; rd_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: got cnt=%0d e=%b f=%b req 0 1 0",
               count, empty, full);
    end
    checks++;
    if (ovr !== 1'b0 || se_cnt !== 8'd0 || rd_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags: got ovr=%b se=%0d rd=%h req 0 0 00",
               ovr, se_cnt, rd_data);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d [3];
    logic       p [3];
    d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'hFF;
    p[0] = 1'b0;  p[1] = 1'b1;  p[2] = 1'b0;
    frame(d[0], p[0], 1'b0, 1'b0);
    checks++;
    if (empty !== 1'b0 || rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_latency: got e=%b rd=%h req 0 a5", empty, rd_data);
    end
    frame(d[1], p[1], 1'b0, 1'b0);
    frame(d[2], p[2], 1'b0, 1'b0);
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL basic_count: got %0d req 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_data !== d[i] || rd_pe !== p[i]) begin
        errors++;
        $display("FAIL basic_pop%0d: got %h/%b req %h/%b",
                 i, rd_data, rd_pe, d[i], p[i]);
      end
      pop();
    end
    checks++;
    if (empty !== 1'b1 || rd_data !== 8'h00 || rd_pe !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty: got e=%b rd=%h pe=%b req 1 00 0",
               empty, rd_data, rd_pe);
    end
    pop();
    checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL pop_when_empty: got cnt=%0d e=%b req 0 1", count, empty);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) frame(8'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL ovr_full: got f=%b cnt=%0d req 1 8", full, count);
    end
    frame(8'h55, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ovr !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL ovr_set: got ovr=%b cnt=%0d req 1 8", ovr, count);
    end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clr: got %b req 0", ovr);
    end
    clr = 1'b1;
    frame(8'h66, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_wins: got %b req 1", ovr);
    end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data !== 8'(i)) begin
        errors++;
        $display("FAIL ovr_drain%0d: got %h req %h", i, rd_data, 8'(i));
      end
      pop();
    end
    checks++;
    if (empty !== 1'b1 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_end: got e=%b ovr=%b req 1 0", empty, ovr);
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) frame(8'(i), 1'b0, 1'b0, 1'b0);
    frame(8'h99, 1'b0, 1'b0, 1'b1);
    checks++;
    if (count !== 4'd8 || ovr !== 1'b0 || rd_data !== 8'h01) begin
      errors++;
      $display("FAIL full_rw: got cnt=%0d ovr=%b rd=%h req 8 0 01",
               count, ovr, rd_data);
    end
    for (int i = 1; i < 9; i++) begin
      exp = (i == 8) ? 8'h99 : 8'(i);
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("FAIL full_rw_drain%0d: got %h req %h", i, rd_data, exp);
      end
      pop();
    end
  endtask

  task automatic test_empty_rw();
    frame(8'h42, 1'b1, 1'b0, 1'b1);
    checks++;
    if (count !== 4'd1 || rd_data !== 8'h42 || rd_pe !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw: got cnt=%0d rd=%h pe=%b req 1 42 1",
               count, rd_data, rd_pe);
    end
    pop();
  endtask

  task automatic test_stop_err();
    for (int i = 0; i < 3; i++) frame(8'hE0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (se_cnt !== 8'd3 || count !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL se_cnt3: got se=%0d cnt=%0d req 3 0", se_cnt, count);
    end
    for (int i = 3; i < 255; i++) frame(8'hE1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (se_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL se_cnt_max: got %h req ff", se_cnt);
    end
    frame(8'hE2, 1'b0, 1'b1, 1'b0);
    checks++;
    if (se_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL se_cnt_sat: got %h req ff", se_cnt);
    end
    for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    frame(8'hE3, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ovr !== 1'b0 || count !== 4'd8 || rd_data !== 8'h10) begin
      errors++;
      $display("FAIL se_full: got ovr=%b cnt=%0d rd=%h req 0 8 10",
               ovr, count, rd_data);
    end
    for (int i = 0; i < 8; i++) pop();
  endtask

  task automatic test_wrap_reset();
    logic [8:0] q[$];
    logic [8:0] h;
    logic       rd;
    for (int i = 0; i < 20; i++) begin
      rd = (i % 3 != 0);
      if (rd && q.size() > 0) begin
        h = q.pop_front();
        checks++;
        if ({rd_pe, rd_data} !== h) begin
          errors++;
          $display("FAIL wrap_head%0d: got %h req %h", i, {rd_pe, rd_data}, h);
        end
      end
      q.push_back({1'(i), 8'(i * 7 + 3)});
      frame(8'(i * 7 + 3), 1'(i), 1'b0, rd);
    end
    checks++;
    if (count !== 4'(q.size())) begin
      errors++;
      $display("FAIL wrap_count: got %0d req %0d", count, q.size());
    end
    while (q.size() > 0) begin
      h = q.pop_front();
      checks++;
      if ({rd_pe, rd_data} !== h) begin
        errors++;
        $display("FAIL wrap_drain: got %h req %h", {rd_pe, rd_data}, h);
      end
      pop();
    end
    for (int i = 0; i < 9; i++) frame(8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pop();
    checks++;
    if (count !== 4'd5 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst: got cnt=%0d ovr=%b req 5 1", count, ovr);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || ovr !== 1'b0 ||
        se_cnt !== 8'd0 || rd_data !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst: got cnt=%0d e=%b ovr=%b se=%0d rd=%h req 0 1 0 0 00",
               count, empty, ovr, se_cnt, rd_data);
    end
    frame(8'h77, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd1 || rd_data !== 8'h77) begin
      errors++;
      $display("FAIL post_rst: got cnt=%0d rd=%h req 1 77", count, rd_data);
    end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_pe = 1'b0;
    wr_se = 1'b0; rd_en = 1'b0; clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overrun();
    test_full_rw();
    test_empty_rw();
    test_stop_err();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
